// File: rtl/ram_dump_tx.sv
// ============================================================================
//  Module   : ram_dump_tx
//  Purpose  : Reads a block of 32-bit RAM words over port B and streams each
//             word MSB-first as four bytes through the uart_tx handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dump_tx #(
    parameter int SIZE   = 10,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] startAddr,
    input  logic [SIZE:0]   wordCount,
    output logic [SIZE-1:0] addrb,
    input  logic [31:0]     doutb,
    output logic            txStart,
    output logic [7:0]      txOut,
    input  logic            txDone,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT    = 3'd2,
        S_LOAD    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5,
        S_NEXT    = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    // RD_LAT is 1 or 2, so the residual wait count fits in one bit.
    localparam logic LAT_INIT = 1'(RD_LAT - 1);

    state_t            state_q,     state_d;
    logic [SIZE-1:0]   cur_addr_q,  cur_addr_d;
    logic [SIZE:0]     remaining_q, remaining_d;
    logic              lat_q,       lat_d;
    logic [1:0]        byte_idx_q,  byte_idx_d;
    logic [31:0]       shift_q,     shift_d;
    logic [SIZE-1:0]   addrb_q,     addrb_d;
    logic [7:0]        txout_q,     txout_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            lat_q       <= 1'b0;
            byte_idx_q  <= 2'd0;
            shift_q     <= 32'd0;
            addrb_q     <= '0;
            txout_q     <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            lat_q       <= lat_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            addrb_q     <= addrb_d;
            txout_q     <= txout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        lat_d       = lat_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = startAddr;
                    remaining_d = wordCount;
                    busy_d      = 1'b1;
                    state_d     = (wordCount == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 1'b0) state_d = S_LOAD;
                else               lat_d   = lat_q - 1'b1;
            end
            S_LOAD: begin
                shift_d    = doutb;
                byte_idx_d = 2'd0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (txDone) begin
                    shift_d    = {shift_q[23:0], 8'h00};
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = (byte_idx_q == 2'd3) ? S_NEXT : S_SEND;
                end
            end
            S_NEXT: begin
                cur_addr_d  = cur_addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == (SIZE+1)'(1)) ? S_FIN : S_READ;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and byte registers update on entry so they are valid in READ/SEND.
    always_comb begin
        addrb_d = addrb_q;
        txout_d = txout_q;
        if (state_d == S_READ) addrb_d = cur_addr_d;
        if (state_d == S_SEND) txout_d = shift_d[31:24];
    end

    assign addrb   = addrb_q;
    assign txOut   = txout_q;
    assign txStart = (state_q == S_SEND);
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_dump_tx.sv
// ============================================================================
//  Module   : tb_ram_dump_tx
//  Purpose  : Self-checking bench for ram_dump_tx with a RAM and uart_tx model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_dump_tx;

    localparam int SIZE   = 10;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] startAddr = '0;
    logic [SIZE:0]   wordCount = '0;
    logic [SIZE-1:0] addrb;
    logic [31:0]     doutb;
    logic            txStart;
    logic [7:0]      txOut;
    logic            txDone = 1'b0;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ram_dump_tx #(.SIZE(SIZE), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .startAddr (startAddr),
        .wordCount (wordCount),
        .addrb     (addrb),
        .doutb     (doutb),
        .txStart   (txStart),
        .txOut     (txOut),
        .txDone    (txDone),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with RD_LAT cycles of read latency.
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[addrb];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign doutb = rd_pipe[RD_LAT-1];

    // uart_tx model and transfer monitor.
    logic       clr_mon = 1'b0;
    logic [7:0] got_bytes [$];
    int         got_addr  [$];
    int         n_tx = 0, n_done = 0, first_tx_cyc = -1, done_cyc = -1, tx_cnt = 0;

    always @(negedge clk) begin
        if (txDone) txDone = 1'b0;
        if (rst) tx_cnt = 0;
        else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) txDone = 1'b1;
        end
        if (clr_mon) begin
            got_bytes.delete();
            got_addr.delete();
            n_tx = 0; n_done = 0; first_tx_cyc = -1; done_cyc = -1;
        end else begin
            if (txStart === 1'b1) begin
                if (n_tx % 4 == 0) got_addr.push_back(int'(addrb));
                got_bytes.push_back(txOut);
                if (n_tx == 0) first_tx_cyc = cyc;
                n_tx++;
                tx_cnt = 10;
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        tick();
        clr_mon = 1'b0;
    endtask

    task automatic do_dump(input int sa, input int wc, input bit interfere);
        logic [7:0] exp_bytes [$];
        int         exp_addr  [$];
        int         s, guard, a;
        bit         injected;
        logic [SIZE-1:0] addr_before;
        injected = 1'b0;
        clear_mon();
        for (int w = 0; w < wc; w++) begin
            a = (sa + w) % DEPTH;
            exp_addr.push_back(a);
            for (int b = 0; b < 4; b++) exp_bytes.push_back(mem[a][31-8*b -: 8]);
        end
        addr_before = addrb;
        startAddr = SIZE'(sa);
        wordCount = (SIZE+1)'(wc);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        guard = 0;
        while (n_done == 0 && guard < 60 * wc + 50) begin
            if (interfere && !injected && n_tx == 1 && cyc >= first_tx_cyc + 3) begin
                start = 1'b1;
                startAddr = SIZE'(sa + 7);
                wordCount = (SIZE+1)'(2);
                injected = 1'b1;
                tick();
                start = 1'b0;
            end else begin
                tick();
            end
            guard++;
        end
        chk("done_seen", 64'(n_done != 0), 64'd1);
        tick(4);
        chk("done_once", 64'(n_done), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("tx_count", 64'(n_tx), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++)
            chk($sformatf("byte[%0d]", i), (i < got_bytes.size()) ? 64'(got_bytes[i]) : 64'h1FF,
                64'(exp_bytes[i]));
        for (int i = 0; i < exp_addr.size(); i++)
            chk($sformatf("addrb[%0d]", i), (i < got_addr.size()) ? 64'(got_addr[i]) : 64'hFFFF,
                64'(exp_addr[i]));
        if (wc > 0) begin
            chk("first_tx_latency", 64'(first_tx_cyc - s), 64'd4);
        end else begin
            chk("done_latency", 64'(done_cyc - s), 64'd2);
            chk("addrb_unchanged", 64'(addrb), 64'(addr_before));
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;

        // Reset held with start asserted: nothing may launch.
        rst = 1'b1;
        start = 1'b1;
        startAddr = SIZE'(5);
        wordCount = (SIZE+1)'(1);
        tick(3);
        chk("rst_addrb", 64'(addrb), 64'd0);
        chk("rst_txStart", 64'(txStart), 64'd0);
        chk("rst_txOut", 64'(txOut), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        clear_mon();
        rst = 1'b0;
        start = 1'b0;
        tick(10);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_no_tx", 64'(n_tx), 64'd0);

        // Single known word.
        do_dump(5, 1, 1'b0);
        chk("deadbeef", (got_bytes.size() == 4) ?
            64'({got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}) : 64'h0, 64'hDEADBEEF);

        // Address wrap at the top of the RAM.
        do_dump(DEPTH - 2, 3, 1'b0);

        // Empty dump.
        do_dump(17, 0, 1'b0);

        // Extra start while a byte is in flight must be ignored.
        do_dump(100, 2, 1'b1);

        // Reset in the middle of a two-word dump.
        clear_mon();
        startAddr = SIZE'(200);
        wordCount = (SIZE+1)'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (n_tx < 2 && guard < 200) begin
            tick();
            guard++;
        end
        chk("midrst_reached_2nd_tx", 64'(n_tx), 64'd2);
        rst = 1'b1;
        tick();
        chk("midrst_txStart", 64'(txStart), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(40);
        chk("midrst_no_more_tx", 64'(n_tx), 64'd2);
        chk("midrst_no_done", 64'(n_done), 64'd0);
        do_dump(200, 1, 1'b0);

        // Randomized dumps.
        for (int r = 0; r < 3; r++)
            do_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_dump_tx.md
Name: ram_dump_tx

Overview:
- Read-back path of the RS232 debug interface. It is the transmit-side counterpart of the host-to-RAM loader.
- On a start pulse, reads a block of 32-bit words from the program/data RAM through port B and serializes each word into 4 bytes, MSB first.
- Bytes are handed one at a time to the uart_tx unit using its tx_start / tx_done_tick handshake.
- Lets the host dump CPU memory after a frozen run.

Parameters:
- SIZE, 10, RAM address width; the address space is 2^SIZE words.
- RD_LAT, 1, RAM port-B read latency in clock cycles; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- startAddr  input  SIZE  first word address; captured on the accepted start.
- wordCount  input  SIZE+1  number of words to send (0..2^SIZE); captured on the accepted start.
- addrb  output  SIZE  RAM port-B address.
- doutb  input  32  RAM port-B read data, valid RD_LAT cycles after addrb.
- txStart  output  1  one-cycle strobe to uart_tx; txOut is valid in the same cycle.
- txOut  output  8  byte to transmit.
- txDone  input  1  tx_done_tick from uart_tx, asserted at the end of the stop bit.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - addrb=0, txStart=0, txOut=0, busy=0, done=0.
  - Internal address/count/byte registers cleared; shift register = 0.
  - Reset mid-dump aborts immediately. No further txStart is issued. uart_tx shares rst, so the byte in flight is also abandoned.
- FSM states: IDLE, READ, WAIT, LOAD, SEND, WAIT_TX, NEXT, FIN.
- IDLE:
  - start=1 captures curAddr=startAddr and remaining=wordCount; busy goes 1 next cycle.
  - If wordCount=0, go to FIN. Otherwise go to READ.
  - start while not in IDLE is ignored (no queuing).
- READ: drive addrb=curAddr; load latency counter with RD_LAT-1; go to WAIT. addrb holds its value until the next READ.
- WAIT: decrement the latency counter; at 0 go to LOAD. With RD_LAT=1, WAIT lasts exactly one cycle.
- LOAD: capture doutb into a 32-bit shift register; byteIdx=0; go to SEND.
- SEND:
  - txOut=shift[31:24], txStart=1 for exactly one cycle; go to WAIT_TX.
  - txOut holds its value until the next SEND.
- WAIT_TX:
  - Wait for txDone=1, then shift left by 8 and increment byteIdx.
  - If byteIdx was 3, go to NEXT; otherwise go to SEND.
  - No timeout. txDone seen in any other state is ignored.
- NEXT:
  - curAddr = curAddr+1 modulo 2^SIZE (wraps 2^SIZE-1 → 0).
  - remaining = remaining-1. At 0 go to FIN; otherwise go to READ.
- FIN: done=1 for one cycle, busy=0 from the next cycle; go to IDLE.
- Timing:
  - Start-to-first-txStart latency with RD_LAT=1 is 4 cycles: start accepted at cycle 0; READ at 1, WAIT at 2, LOAD at 3, SEND at 4.
  - Byte-to-byte spacing is txDone + 1 cycle.
  - A wordCount of 2^SIZE dumps the entire RAM exactly once.
- The block never writes RAM. It drives no web; the loader owns web.

Test Plan:
- Reset with start held high -> all outputs 0, no txStart, state IDLE after release; start is accepted only when held on a cycle with rst=0.
- RAM[5]=0xDEADBEEF, start with startAddr=5, wordCount=1, uart_tx model returns txDone 10 cycles after each txStart -> txOut sequence 0xDE, 0xAD, 0xBE, 0xEF; exactly 4 txStart pulses; first txStart 4 cycles after start; done pulse after the fourth txDone; busy low afterwards.
- startAddr=1022, wordCount=3, SIZE=10 -> addrb sequence 1022, 1023, 0; 12 bytes sent in order; done pulsed once.
- wordCount=0 -> no addrb change, no txStart, done pulses 2 cycles after start.
- Second start pulse issued during WAIT_TX -> ignored; byte count and addresses unchanged; single done.
- rst asserted after the second txStart of a 2-word dump -> next cycle txStart=0, busy=0; no further bytes; a later start with wordCount=1 runs cleanly from startAddr.
